// File: rtl/readout_sequencer.sv
// Per-shot readout controller: arm on run, trigger delay, collect, result handshake, config gating.
// Optional COLLECT watchdog is compiled in when SEQ_TIMEOUT_EN is defined.
module readout_sequencer #(
  parameter int SHOT_W  = 16,
  parameter int DELAY_W = 14
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic              clk100,
  input  logic              reset_n,
  input  logic              run,
  input  logic [SHOT_W-1:0] num_shots,
  input  logic [DELAY_W-1:0] delay_time,
  input  logic              config_update,
  output logic              config_load,
  input  logic              trigger,
  output logic              start_collect,
  input  logic              iq_valid,
  input  logic [31:0]       i_val,
  input  logic [31:0]       q_val,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_i,
  output logic [31:0]       res_q,
  output logic [SHOT_W-1:0] res_shot,
  output logic              busy,
  output logic              done,
  output logic [SHOT_W-1:0] missed_trig,
  output logic              timeout_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] DELAY   = 3'd2;
  localparam logic [2:0] COLLECT = 3'd3;
  localparam logic [2:0] OUTPUT  = 3'd4;

  logic [2:0]         state;
  logic [SHOT_W-1:0]  shots_lat;
  logic [SHOT_W-1:0]  shot_count;
  logic [SHOT_W-1:0]  next_shot;
  logic [DELAY_W-1:0] delay_lat;
  logic [DELAY_W-1:0] delay_cnt;
  logic               cfg_pending;
  logic               run_start;
  logic               handshake;
  logic               last_shot;
  logic               collect_abort;

  // start_collect is decoded from the delay count so delay_time=0 fires the cycle after the trigger
  assign start_collect = (state == DELAY) && run && (delay_cnt == delay_lat);
  assign run_start     = (state == IDLE) && !cfg_pending && run;
  assign handshake     = (state == OUTPUT) && res_valid && res_ready;
  assign next_shot     = shot_count + SHOT_W'(1);
  assign last_shot     = (shots_lat != '0) && (next_shot == shots_lat);
  assign busy          = (state != IDLE);

`ifdef SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_flag;

  assign collect_abort = (state == COLLECT) && !iq_valid &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err   = to_flag;

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == COLLECT) to_cnt <= to_cnt + TO_W'(1);
      else                  to_cnt <= '0;
      if (collect_abort)  to_flag <= 1'b1;
      else if (run_start) to_flag <= 1'b0;
    end
  end
`else
  assign collect_abort = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      state       <= IDLE;
      shots_lat   <= '0;
      shot_count  <= '0;
      delay_lat   <= '0;
      delay_cnt   <= '0;
      cfg_pending <= 1'b0;
      config_load <= 1'b0;
      res_valid   <= 1'b0;
      res_i       <= '0;
      res_q       <= '0;
      res_shot    <= '0;
      done        <= 1'b0;
      missed_trig <= '0;
    end else begin
      config_load <= 1'b0;
      done        <= 1'b0;
      if (config_update) cfg_pending <= 1'b1;
      if (trigger && busy && (state != ARMED) && (missed_trig != '1))
        missed_trig <= missed_trig + SHOT_W'(1);

      case (state)
        IDLE: begin
          // A pending config load always wins over starting a run
          if (cfg_pending) begin
            config_load <= 1'b1;
            cfg_pending <= config_update;
          end else if (run_start) begin
            state       <= ARMED;
            shots_lat   <= num_shots;
            delay_lat   <= delay_time;
            shot_count  <= '0;
            missed_trig <= '0;
          end
        end
        ARMED: begin
          if (!run) state <= IDLE;
          else if (trigger) begin
            state     <= DELAY;
            delay_cnt <= '0;
          end
        end
        DELAY: begin
          if (!run)               state <= IDLE;
          else if (start_collect) state <= COLLECT;
          else                    delay_cnt <= delay_cnt + DELAY_W'(1);
        end
        COLLECT: begin
          if (iq_valid) begin
            res_i     <= i_val;
            res_q     <= q_val;
            res_shot  <= shot_count;
            res_valid <= 1'b1;
            state     <= OUTPUT;
          end else if (collect_abort) begin
            state <= IDLE;
          end
        end
        OUTPUT: begin
          if (handshake) begin
            res_valid  <= 1'b0;
            shot_count <= next_shot;
            if (last_shot) begin
              done  <= 1'b1;
              state <= IDLE;
            end else if (!run) state <= IDLE;
            else               state <= ARMED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
